// File: rtl/mem_stage.sv
// Memory pipeline stage. It takes one execute result per cycle. ALU, branch, jump and
// unrecognised ops write back one cycle later. Aligned LDW/SDW issue one dmem request
// and hold it until dmem_ack.
// Opcode encodings mirror def.v (MIPS-style primary opcodes for memory and branch,
// funct-style codes for ALU ops).
// Optional feature: define MEM_TIMEOUT_EN to add an 8-bit access timeout and the
// err_timeout output.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_out,
  input  logic        zf,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        branch_taken,
`ifdef MEM_TIMEOUT_EN
  output logic        err_timeout,
`endif
  output logic        err_misalign
);

  localparam logic [5:0] OpLdw  = 6'h23;
  localparam logic [5:0] OpSdw  = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpJump = 6'h02;
  localparam logic [5:0] OpAdd  = 6'h20;
  localparam logic [5:0] OpSub  = 6'h22;
  localparam logic [5:0] OpAnd  = 6'h24;
  localparam logic [5:0] OpOr   = 6'h25;
  localparam logic [5:0] OpXor  = 6'h26;
  localparam logic [5:0] OpSlt  = 6'h2A;

  typedef enum logic [0:0] {StIdle, StMem} state_e;

  state_e state_q;
  logic   is_mem, is_load, is_alu, is_branch, aligned;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
`endif

  assign in_ready = (state_q == StIdle);

  // Decode the incoming opcode into the few classes the stage cares about.
  always_comb begin
    is_mem    = 1'b0;
    is_load   = 1'b0;
    is_alu    = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OpLdw: begin
        is_mem  = 1'b1;
        is_load = 1'b1;
      end
      OpSdw:                                    is_mem    = 1'b1;
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt:  is_alu    = 1'b1;
      OpBeq:                                    is_branch = zf;
      OpJump:                                   is_branch = 1'b1;
      default: ;
    endcase
    aligned = (alu_out[1:0] == 2'b00);
  end

  // FSM with registered memory-port and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_data      <= 32'h0;
      wb_dest      <= 5'h0;
      branch_taken <= 1'b0;
      err_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_timeout  <= 1'b0;
      tmo_cnt_q    <= 8'h0;
`endif
    end else begin
      // Status outputs are single-cycle pulses unless set below.
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      branch_taken <= 1'b0;
      err_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            wb_dest <= dest;
            if (is_mem && aligned) begin
              dmem_req   <= 1'b1;
              dmem_we    <= ~is_load;
              dmem_addr  <= alu_out;
              dmem_wdata <= store_data;
              state_q    <= StMem;
`ifdef MEM_TIMEOUT_EN
              tmo_cnt_q  <= 8'h0;
`endif
            end else begin
              wb_valid     <= 1'b1;
              wb_data      <= alu_out;
              wb_we        <= is_alu && (dest != 5'd0);
              branch_taken <= is_branch;
              err_misalign <= is_mem;
            end
          end
        end
        StMem: begin
          // dmem_addr still holds the effective address, which is the SDW result.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= dmem_we ? dmem_addr : dmem_rdata;
            wb_we    <= ~dmem_we && (wb_dest != 5'd0);
            state_q  <= StIdle;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt_q == 8'd255) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= dmem_addr;
            err_timeout <= 1'b1;
            state_q     <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued at issue time and a
// negedge monitor pops and compares them whenever wb_valid is seen.
module tb_mem_stage;

  localparam logic [5:0] OpLdw  = 6'h23;
  localparam logic [5:0] OpSdw  = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpJump = 6'h02;
  localparam logic [5:0] OpAdd  = 6'h20;
  localparam logic [5:0] OpSub  = 6'h22;
  localparam logic [5:0] OpBad  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'h0;
  logic [31:0] alu_out = 32'h0;
  logic        zf = 1'b0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  dest = 5'h0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_valid, wb_we, branch_taken, err_misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
`ifdef MEM_TIMEOUT_EN
  logic        err_timeout;
`endif

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .alu_out      (alu_out),
    .zf           (zf),
    .store_data   (store_data),
    .dest         (dest),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .branch_taken (branch_taken),
`ifdef MEM_TIMEOUT_EN
    .err_timeout  (err_timeout),
`endif
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        br;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] data, input logic [4:0] d,
                              input logic br, input logic mis, input logic tmo);
    exp_t e;
    e.we = we; e.data = data; e.dest = d; e.br = br; e.mis = mis; e.tmo = tmo;
    return e;
  endfunction

  // Monitor: every wb_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_we", 32'(wb_we), 32'(e.we));
        check("wb_data", wb_data, e.data);
        check("wb_dest", 32'(wb_dest), 32'(e.dest));
        check("branch_taken", 32'(branch_taken), 32'(e.br));
        check("err_misalign", 32'(err_misalign), 32'(e.mis));
`ifdef MEM_TIMEOUT_EN
        check("err_timeout", 32'(err_timeout), 32'(e.tmo));
`endif
      end
    end
  end

  // Present one op for exactly one accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic z,
                       input logic [31:0] sd, input logic [4:0] d);
    @(negedge clk);
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = op; alu_out = alu; zf = z; store_data = sd; dest = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Hold off ack for n request cycles, checking the request is stable, then ack.
  task automatic mem_wait(input int n, input logic [31:0] rdata, input logic [31:0] addr,
                          input logic we, input logic [31:0] wdata);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check("dmem_req_held", 32'(dmem_req), 32'd1);
      check("dmem_addr", dmem_addr, addr);
      check("dmem_we", 32'(dmem_we), 32'(we));
      check("dmem_wdata", dmem_wdata, wdata);
      check("in_ready_mem", 32'(in_ready), 32'd0);
      if (i == n) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
    end
    @(posedge clk);
    #1 dmem_ack = 1'b0;
  endtask

  initial begin
    int req_cycles;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_dest", 32'(wb_dest), 32'd0);

    // ALU ops, back-to-back branches, dest=0, jump, unknown opcode.
    exp_q.push_back(mk(1'b1, 32'h5, 5'd3, 1'b0, 1'b0, 1'b0));
    issue(OpAdd, 32'h5, 1'b0, 32'h0, 5'd3);
    exp_q.push_back(mk(1'b1, 32'hFFFF_FFFE, 5'd9, 1'b0, 1'b0, 1'b0));
    issue(OpSub, 32'hFFFF_FFFE, 1'b0, 32'h0, 5'd9);
    exp_q.push_back(mk(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    issue(OpBeq, 32'h0, 1'b1, 32'h0, 5'd0);
    exp_q.push_back(mk(1'b0, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0));
    issue(OpBeq, 32'h1, 1'b0, 32'h0, 5'd0);
    exp_q.push_back(mk(1'b0, 32'h77, 5'd0, 1'b0, 1'b0, 1'b0));
    issue(OpAdd, 32'h77, 1'b0, 32'h0, 5'd0);
    exp_q.push_back(mk(1'b0, 32'h400, 5'd31, 1'b1, 1'b0, 1'b0));
    issue(OpJump, 32'h400, 1'b0, 32'h0, 5'd31);
    exp_q.push_back(mk(1'b0, 32'hABCD, 5'd6, 1'b0, 1'b0, 1'b0));
    issue(OpBad, 32'hABCD, 1'b1, 32'h0, 5'd6);

    // LDW with ack on the third request cycle.
    exp_q.push_back(mk(1'b1, 32'hDEAD_BEEF, 5'd8, 1'b0, 1'b0, 1'b0));
    issue(OpLdw, 32'h100, 1'b0, 32'h0, 5'd8);
    mem_wait(3, 32'hDEAD_BEEF, 32'h100, 1'b0, 32'h0);
    @(negedge clk);
    check("ldw_req_drop", 32'(dmem_req), 32'd0);

    // SDW acked in the cycle the request rises.
    exp_q.push_back(mk(1'b0, 32'h104, 5'd7, 1'b0, 1'b0, 1'b0));
    issue(OpSdw, 32'h104, 1'b0, 32'h55, 5'd7);
    mem_wait(1, 32'h0, 32'h104, 1'b1, 32'h55);
    @(negedge clk);
    check("sdw_req_drop", 32'(dmem_req), 32'd0);

    // Misaligned LDW: no request, error writeback.
    exp_q.push_back(mk(1'b0, 32'h102, 5'd4, 1'b0, 1'b1, 1'b0));
    issue(OpLdw, 32'h102, 1'b0, 32'h0, 5'd4);
    @(negedge clk);
    check("misalign_no_req", 32'(dmem_req), 32'd0);

    // Stray ack while idle produces nothing (the monitor flags any wb_valid).
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_req", 32'(dmem_req), 32'd0);
    check("idle_ack_ready", 32'(in_ready), 32'd1);

    // Reset mid-access, with a concurrent in_valid, then a late ack.
    issue(OpLdw, 32'h200, 1'b0, 32'h0, 5'd5);
    @(negedge clk);
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1; in_valid = 1'b1; opcode = OpAdd; alu_out = 32'h9; dest = 5'd2;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_mem_req", 32'(dmem_req), 32'd0);
    check("rst_mem_ready", 32'(in_ready), 32'd1);
    check("rst_mem_wb", 32'(wb_valid), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("late_ack_wb", 32'(wb_valid), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // No ack: request stays up for 256 cycles, then a timeout writeback.
    exp_q.push_back(mk(1'b0, 32'h300, 5'd10, 1'b0, 1'b0, 1'b1));
    issue(OpLdw, 32'h300, 1'b0, 32'h0, 5'd10);
    req_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dmem_req) req_cycles++;
    end
    check("timeout_req_cycles", 32'(req_cycles), 32'd256);
    check("timeout_ready", 32'(in_ready), 32'd1);
`else
    req_cycles = 0;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL: in_valid  input  1  execute result present this cycle.
REQ-004 SHALL: in_ready  output  1  stage accepts an operation this cycle.
REQ-005 SHALL: opcode  input  6  operation; encodings from def.v (LDW, SDW, BEQ, ADD, SUB, AND, OR, XOR, SLT, JUMP).
REQ-006 SHALL: alu_out  input  32  ALU result; the effective address for LDW/SDW.
REQ-007 SHALL: zf  input  1  ALU zero flag.
REQ-008 SHALL: store_data  input  32  rt value for SDW.
REQ-009 SHALL: dest  input  5  destination register index.
REQ-010 SHALL: dmem_req, dmem_we  output  1 each  memory request / write strobe.
REQ-011 SHALL: dmem_addr, dmem_wdata  output  32 each  memory address / write data.
REQ-012 SHALL: dmem_ack  input  1  memory completion; dmem_rdata  input  32  load data, valid with ack.
REQ-013 SHALL: wb_valid, wb_we  output  1 each  result pulse / register-write enable.
REQ-014 SHALL: wb_data  output  32; wb_dest  output  5  writeback value and index.
REQ-015 SHALL: branch_taken, err_misalign  output  1 each  status, qualified by wb_valid.

Function
REQ-016 SHALL: FSM states IDLE, MEM; in_ready = (state==IDLE); an operation is accepted when in_valid & in_ready.
REQ-017 SHALL: non-memory op accepted in IDLE -> next cycle wb_valid=1 for exactly one cycle, wb_data=alu_out, wb_dest=dest; state stays IDLE (1-cycle latency, one op per cycle).
REQ-018 SHALL: wb_we=1 only for ADD, SUB, AND, OR, XOR, SLT, LDW with dest!=0; otherwise 0.
REQ-019 SHALL: branch_taken=1 with wb_valid for BEQ whose captured zf=1, and for JUMP; else 0.
REQ-020 SHALL: LDW/SDW with alu_out[1:0]==0 -> next cycle dmem_req=1, dmem_addr=alu_out, dmem_we=(SDW), dmem_wdata=store_data; state MEM.
REQ-021 SHALL: in MEM, dmem_req and all dmem_* outputs held stable until the cycle dmem_ack=1; ack in the same cycle req first rises is legal.
REQ-022 SHALL: on dmem_ack in MEM -> next cycle dmem_req=0, wb_valid=1, wb_data=dmem_rdata (LDW) or alu_out (SDW), state IDLE; no new op accepted while in MEM.
REQ-023 SHALL: LDW/SDW with alu_out[1:0]!=0 -> no memory request; next cycle wb_valid=1, err_misalign=1, wb_we=0.
REQ-024 SHALL: unrecognised opcode -> wb_valid=1, wb_we=0, branch_taken=0 (no-op).
REQ-025 SHALL: dmem_ack while state IDLE is ignored.

Reset
REQ-026 SHALL: rst=1 at a clock edge -> state IDLE; dmem_req, dmem_we, wb_valid, wb_we, branch_taken, err_misalign = 0; dmem_addr, dmem_wdata, wb_data = 0; wb_dest = 0.
REQ-027 SHALL: rst during MEM abandons the access: dmem_req=0 next cycle, no wb_valid for it; a later ack is ignored.
REQ-028 SHALL: rst has priority over in_valid and dmem_ack in the same cycle.

Configuration
REQ-029 SHALL: macro MEM_TIMEOUT_EN defined -> 8-bit counter cleared on entering MEM, incremented each MEM cycle without ack; at count 255 without ack -> dmem_req=0, wb_valid=1, wb_we=0, err_timeout=1 (extra 1-bit output), state IDLE.
REQ-030 SHALL: MEM_TIMEOUT_EN undefined -> no counter, no err_timeout port; MEM waits indefinitely for dmem_ack.

Verification
REQ-031 SHALL: ADD, alu_out=0x0000_0005, dest=3 -> next cycle wb_valid=1, wb_we=1, wb_data=5, wb_dest=3.
REQ-032 SHALL: LDW alu_out=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> req held 3 cycles, in_ready=0 throughout, then wb_data=0xDEADBEEF, wb_we=1.
REQ-033 SHALL: SDW alu_out=0x104, store_data=0x55, ack same cycle as req -> dmem_we=1, dmem_wdata=0x55, wb_valid next cycle with wb_we=0.
REQ-034 SHALL: LDW alu_out=0x102 -> dmem_req never rises, err_misalign=1, wb_we=0.
REQ-035 SHALL: BEQ zf=1 then BEQ zf=0 back-to-back -> branch_taken 1 then 0 on consecutive wb_valid cycles; ADD with dest=0 -> wb_we=0.
REQ-036 SHALL: rst asserted mid-MEM, then ack -> no wb_valid; with MEM_TIMEOUT_EN, no ack for 255 cycles -> err_timeout=1, state IDLE.
